// File: rtl/dws_pkg.sv
// Shared types for the delay/write sequencer: write targets, FSM states and
// the queued entry layout at the default field widths.
package dws_pkg;

    localparam int DWS_DATA_W = 32;
    localparam int DWS_DLY_W  = 8;

    typedef enum logic [1:0] {
        TGT_A    = 2'd0,
        TGT_B    = 2'd1,
        TGT_C    = 2'd2,
        TGT_NONE = 2'd3
    } target_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_COUNT,
        ST_APPLY,
        ST_FIN
    } state_e;

    // Default-width entry; the top re-declares the same layout at its own
    // parameter widths so DATA_W/DLY_W overrides stay consistent.
    typedef struct packed {
        logic [DWS_DLY_W-1:0]  delay;
        target_e               target;
        logic [DWS_DATA_W-1:0] value;
    } entry_t;

endpackage

// File: rtl/dws_fifo.sv
// Synchronous FIFO of sequencer entries. The head is read combinationally;
// a pushed entry becomes visible one cycle after the push, and a pop at full
// frees its slot one cycle later, because full/empty come from a registered count.
module dws_fifo
    import dws_pkg::*;
#(
    parameter int  DEPTH      = 8,
    parameter type entry_type = entry_t
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  entry_type wr_data,
    input  logic      pop,
    output entry_type rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    entry_type       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/delay_write_sequencer.sv
// Timed writer for the condition-wait protocol: plays queued
// (delay, target, value) entries out in order onto three watched variables.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; queue accepts pushes
// ST_FETCH | pop head entry, load delay counter
// ST_COUNT | count delay down; hold freezes the countdown
// ST_APPLY | strobe the write (none for TGT_NONE), pick next entry
// ST_FIN   | one-cycle done pulse
module delay_write_sequencer
    import dws_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DWS_DATA_W,
    parameter int DLY_W  = DWS_DLY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DLY_W-1:0]  in_delay,
    input  logic [1:0]        in_target,
    input  logic [DATA_W-1:0] in_value,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [1:0]        wr_target,
    output logic [DATA_W-1:0] wr_value,
    output logic [DATA_W-1:0] var_a,
    output logic [DATA_W-1:0] var_b,
    output logic [DATA_W-1:0] var_c
);

    typedef struct packed {
        logic [DLY_W-1:0]  delay;
        target_e           target;
        logic [DATA_W-1:0] value;
    } entry_w_t;

    state_e            state_q;
    state_e            state_d;
    entry_w_t          push_entry;
    entry_w_t          fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              load_cur;
    logic              dec_cnt;
    logic              do_write;
    logic [DLY_W-1:0]  cnt_q;
    target_e           cur_target;
    logic [DATA_W-1:0] cur_value;
    logic [1:0]        last_target;
    logic [DATA_W-1:0] last_value;

    assign push_entry.delay  = in_delay;
    assign push_entry.target = target_e'(in_target);
    assign push_entry.value  = in_value;

    dws_fifo #(
        .DEPTH      (DEPTH),
        .entry_type (entry_w_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (push_entry),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign wr_en     = do_write;
    // Outside a write strobe the bus keeps showing the last write.
    assign wr_target = do_write ? cur_target : last_target;
    assign wr_value  = do_write ? cur_value  : last_value;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_cur = 1'b0;
        dec_cnt  = 1'b0;
        do_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = fifo_empty ? ST_FIN : ST_FETCH;
            end
            ST_FETCH: begin
                fifo_pop = 1'b1;
                load_cur = 1'b1;
                state_d  = (fifo_head.delay == '0) ? ST_APPLY : ST_COUNT;
            end
            ST_COUNT: begin
                if (!hold) begin
                    if (cnt_q == DLY_W'(1)) state_d = ST_APPLY;
                    else                    dec_cnt = 1'b1;
                end
            end
            ST_APPLY: begin
                do_write = (cur_target != TGT_NONE);
                state_d  = fifo_empty ? ST_FIN : ST_FETCH;
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Current entry, delay counter, last-write bus and watched variables.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_target  <= TGT_A;
            cur_value   <= '0;
            last_target <= '0;
            last_value  <= '0;
            var_a       <= '0;
            var_b       <= '0;
            var_c       <= '0;
        end else begin
            if (load_cur) begin
                cnt_q      <= fifo_head.delay;
                cur_target <= fifo_head.target;
                cur_value  <= fifo_head.value;
            end else if (dec_cnt) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (do_write) begin
                last_target <= cur_target;
                last_value  <= cur_value;
                case (cur_target)
                    TGT_A:   var_a <= cur_value;
                    TGT_B:   var_b <= cur_value;
                    TGT_C:   var_c <= cur_value;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_write_sequencer.sv
// Scoreboard bench: the driver pushes expected writes/done pulses with their
// cycle numbers; the monitor pops and compares whenever the DUT strobes.
module tb_delay_write_sequencer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int DLY_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DLY_W-1:0]  in_delay;
    logic [1:0]        in_target;
    logic [DATA_W-1:0] in_value;
    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [1:0]        wr_target;
    logic [DATA_W-1:0] wr_value;
    logic [DATA_W-1:0] var_a;
    logic [DATA_W-1:0] var_b;
    logic [DATA_W-1:0] var_c;

    delay_write_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_delay  (in_delay),
        .in_target (in_target),
        .in_value  (in_value),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_target (wr_target),
        .wr_value  (wr_value),
        .var_a     (var_a),
        .var_b     (var_b),
        .var_c     (var_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                cyc;
        logic [1:0]        tgt;
        logic [DATA_W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t e;
    int   dexp;
    logic              pend = 1'b0;
    logic [1:0]        pend_tgt;
    logic [DATA_W-1:0] pend_val;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: compare every write strobe and done pulse against the queues.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                case (pend_tgt)
                    2'd0:    chk("var_a_update", var_a, pend_val);
                    2'd1:    chk("var_b_update", var_b, pend_val);
                    default: chk("var_c_update", var_c, pend_val);
                endcase
                pend = 1'b0;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr actual target=%0d value=%0h at cycle %0d required no write",
                             wr_target, wr_value, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_target", wr_target, e.tgt);
                    chk("wr_value", wr_value, e.val);
                    pend     = 1'b1;
                    pend_tgt = e.tgt;
                    pend_val = e.val;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual pulse at cycle %0d required none", cyc);
                end else begin
                    dexp = done_q.pop_front();
                    chk("done_cycle", cyc, dexp);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input int t, input logic [DATA_W-1:0] v);
        int n;
        in_valid  = 1'b1;
        in_delay  = DLY_W'(d);
        in_target = 2'(t);
        in_value  = v;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual in_ready=0 required 1 within 100 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic exp_wr(input int c, input int t, input logic [DATA_W-1:0] v);
        exp_t x;
        x.cyc = c;
        x.tgt = 2'(t);
        x.val = v;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, busy, 0);
        chk({name, "_writes_left"}, exp_q.size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    int t0;
    int n;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_delay = '0; in_target = '0; in_value = '0;
        start = 1'b0; hold = 1'b0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_target", wr_target, 0);
        chk("rst_wr_value", wr_value, 0);
        chk("rst_var_a", var_a, 0);
        chk("rst_var_b", var_b, 0);
        chk("rst_var_c", var_c, 0);
        rst = 1'b0;
        tick();

        // Main sequence: 8 queued, the 9th pushed during playback.
        push(1, 0, 1); push(1, 0, 2); push(1, 0, 0); push(1, 0, 2);
        push(2, 1, 2); push(1, 0, 1); push(1, 2, 3); push(1, 2, 4);
        start = 1'b1; t0 = cyc;
        exp_wr(t0+3, 0, 1);  exp_wr(t0+6, 0, 2);  exp_wr(t0+9, 0, 0);
        exp_wr(t0+12, 0, 2); exp_wr(t0+16, 1, 2); exp_wr(t0+19, 0, 1);
        exp_wr(t0+22, 2, 3); exp_wr(t0+25, 2, 4); exp_wr(t0+28, 1, 5);
        done_q.push_back(t0+29);
        tick(); start = 1'b0;
        push(1, 1, 5);
        wait_idle("seq9");
        chk("seq9_var_a", var_a, 1);
        chk("seq9_var_b", var_b, 5);
        chk("seq9_var_c", var_c, 4);

        // Hold for three cycles mid-countdown.
        push(5, 1, 7);
        start = 1'b1; t0 = cyc;
        exp_wr(t0+10, 1, 7);
        done_q.push_back(t0+11);
        tick(); start = 1'b0;
        tick(2); hold = 1'b1;
        tick(3); hold = 1'b0;
        wait_idle("hold");
        chk("hold_var_b", var_b, 7);

        // Back-to-back zero-delay entries.
        push(0, 0, 9); push(0, 2, 8);
        start = 1'b1; t0 = cyc;
        exp_wr(t0+2, 0, 9); exp_wr(t0+4, 2, 8);
        done_q.push_back(t0+5);
        tick(); start = 1'b0;
        wait_idle("zero_dly");
        chk("zero_var_a", var_a, 9);
        chk("zero_var_c", var_c, 8);

        // Pure delay followed by a zero-delay write.
        push(4, 3, 32'hDEAD_BEEF); push(0, 1, 1);
        start = 1'b1; t0 = cyc;
        exp_wr(t0+8, 1, 1);
        done_q.push_back(t0+9);
        tick(); start = 1'b0;
        wait_idle("pure_dly");
        chk("pure_var_b", var_b, 1);
        chk("pure_var_a_kept", var_a, 9);

        // Fill the queue; the 9th push waits for the first pop.
        for (int i = 0; i < 8; i++) push(0, i % 3, 32'(11 + i));
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_delay = '0; in_target = 2'd2; in_value = 32'd19;
        start = 1'b1; t0 = cyc;
        for (int i = 0; i < 9; i++) exp_wr(t0 + 2 + 2*i, i % 3, 32'(11 + i));
        done_q.push_back(t0+19);
        tick(); start = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push9_accept_cycle", cyc, t0+2);
        tick(); in_valid = 1'b0;
        wait_idle("fill");
        chk("fill_var_a", var_a, 17);
        chk("fill_var_b", var_b, 18);
        chk("fill_var_c", var_c, 19);

        // Start with an empty queue.
        start = 1'b1; t0 = cyc;
        done_q.push_back(t0+1);
        tick(); start = 1'b0;
        wait_idle("empty_start");

        // Reset during COUNT aborts playback and flushes the queue.
        push(10, 0, 5); push(3, 1, 6);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(3);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_var_a", var_a, 0);
        chk("post_rst_var_b", var_b, 0);
        chk("post_rst_var_c", var_c, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_in_ready", in_ready, 1);
        tick(20);
        start = 1'b1; t0 = cyc;
        done_q.push_back(t0+1);
        tick(); start = 1'b0;
        wait_idle("post_rst_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_write_sequencer.md
Name: delay_write_sequencer

Overview:
- Timed stimulus driver: the writer end of the condition-wait protocol.
- Entries (delay, target, value) are queued. After `start`, the block plays them out in order. For each entry it waits `delay` cycles, then writes `value` to one of three watched variables (a, b, c).
- The variables and a write strobe go to a condition-wait consumer, which blocks on predicates over them.
- The consumer can freeze the timeline with `hold`.

Parameters:
- DEPTH, 8, entry queue depth (power of 2, >=2)
- DATA_W, 32, width of variables and entry value
- DLY_W, 8, width of per-entry delay field (cycles)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  entry push request
- in_ready  out  1  queue not full; push happens when in_valid && in_ready
- in_delay  in  DLY_W  cycles to wait before applying the entry
- in_target  in  2  0=a, 1=b, 2=c, 3=pure delay (no write)
- in_value  in  DATA_W  value to write
- start  in  1  begin playback; sampled only in IDLE
- hold  in  1  freezes the delay countdown while high
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when playback completes
- wr_en  out  1  one-cycle strobe; a variable is updated this cycle
- wr_target  out  2  target of the current write
- wr_value  out  DATA_W  value of the current write
- var_a, var_b, var_c  out  DATA_W  current variable values

Behaviour:
- Reset:
  - All outputs 0 except in_ready=1.
  - Queue flushed, variables 0, state IDLE.
  - Reset mid-playback aborts immediately. No done pulse and no further wr_en.
- Queue:
  - Synchronous FIFO, DEPTH entries.
  - in_ready = !full. A push is accepted in any state.
  - A push and a pop in the same cycle are both legal, including at full (pop frees a slot only from the next cycle) and at empty (pushed entry is not poppable until the next cycle).
- FSM states: IDLE, FETCH, COUNT, APPLY, FIN.
  - IDLE, start=1, queue non-empty -> FETCH.
  - IDLE, start=1, queue empty -> FIN (done pulse next cycle, no writes).
  - IDLE: start while busy is ignored.
  - FETCH: pop the head entry, load cnt=delay. Go to APPLY if delay==0, else COUNT.
  - COUNT: cnt decrements each cycle with hold=0; hold=1 freezes cnt and state. Go to APPLY in the cycle cnt reaches 1 with hold=0.
  - APPLY: wr_en=1, wr_target and wr_value from the entry. The selected var register updates at the end of this cycle.
    - target 3: wr_en stays 0 and no var changes; only the time is consumed.
    - hold is ignored in APPLY.
    - Next state: FETCH if the queue is non-empty, else FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Timing:
  - start sampled at cycle T, entry delay d: APPLY at cycle T+2+d; the var is visible at T+3+d.
  - Consecutive delay-0 entries produce wr_en every 2 cycles.
  - Each cycle with hold=1 during COUNT adds one cycle.
- Entries pushed during playback are played if they arrive before the APPLY that would otherwise find the queue empty.
- wr_target and wr_value hold their last values when wr_en=0.
- Variables keep their values across playbacks; they are cleared only by rst.
- Width rules:
  - Delay is unsigned; max wait is 2^DLY_W - 1 cycles.
  - Values are stored verbatim, with no arithmetic.

Decomposition:
- Shared package dws_pkg:
  - target_e enum (TGT_A, TGT_B, TGT_C, TGT_NONE)
  - state_e enum
  - entry_t packed struct {delay, target, value}
- One sub-module, dws_fifo: parameterised sync FIFO of entry_t with full/empty. The FSM and variable registers stay in delay_write_sequencer.

Test Plan:
- Push (1,a,1), (1,a,2), (1,a,0), (1,a,2), (2,b,2), (1,a,1), (1,c,3), (1,c,4), (1,b,5); start at T.
  - Expect 9 wr_en pulses; the first at T+3 (a=1).
  - Final a=1, b=5, c=4; done pulses exactly once, after the last write.
- Hold: entry (5,b,7), hold=1 for 3 cycles mid-countdown -> wr_en at T+10 instead of T+7.
- Push delay 0 entries (0,a,9), (0,c,8) -> wr_en at T+2 and T+4; var_a=9, var_c=8.
- Pure-delay entry (4,3,x) followed by (0,b,1) -> no wr_en for the first entry; b=1 written at T+8.
- Fill all 8 entries -> in_ready=0. The 9th push is held off until FETCH pops an entry, then accepted. All 9 played in order.
- start with empty queue -> done at T+1, no wr_en. rst asserted during COUNT -> vars 0, busy 0, no done, queue empty.
